// File: rtl/mem_wb_stage_if.sv
// EX/MEM -> MEM/WB bundle. The upstream pipeline drives the *_in side through
// the master modport; mem_wb_stage takes the slave side. dbg_state shows the
// wait-state FSM so checkers can observe it. It reads 0 when the FSM is not
// built.
//
// Handshake: stall_out is combinational. While stall_out=1 the master must hold
// every *_in signal stable. The master may present a new operation on the
// cycle after a rising edge at which stall_out was 0.
interface mem_wb_stage_if;
  logic        RegWrite_in;
  logic [31:0] ALU_Result_in;
  logic [31:0] ReadData2_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic        MemToReg_in;
  logic        RegDest_in;
  logic [14:0] rs_rt_rd_in;
  logic        RegWrite_out;
  logic [4:0]  WriteReg_out;
  logic [31:0] WriteData_out;
  logic        misalign_out;
  logic        stall_out;
  logic [1:0]  dbg_state;

  modport master (
    output RegWrite_in, ALU_Result_in, ReadData2_in, MemRead_in, MemWrite_in,
           MemToReg_in, RegDest_in, rs_rt_rd_in,
    input  RegWrite_out, WriteReg_out, WriteData_out, misalign_out, stall_out,
           dbg_state
  );

  modport slave (
    input  RegWrite_in, ALU_Result_in, ReadData2_in, MemRead_in, MemWrite_in,
           MemToReg_in, RegDest_in, rs_rt_rd_in,
    output RegWrite_out, WriteReg_out, WriteData_out, misalign_out, stall_out,
           dbg_state
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MIPS memory-access stage plus the MEM/WB pipeline register.
// The stage does word loads and stores against an internal data memory that is
// cleared on reset. Misaligned accesses are flagged and have no effect.
// Optional macro DMEM_LATENCY_EN adds WAIT_CYCLES wait states per aligned
// access. Without it, stall_out is tied to 0 and every access takes one cycle.
module mem_wb_stage #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input logic           clk,
  input logic           reset,
  mem_wb_stage_if.slave bus
);

  logic [31:0]       mem_q [DEPTH];
  logic              regwrite_q;
  logic [4:0]        wreg_q;
  logic [31:0]       wdata_q;
  logic              misalign_q;

  logic [ADDR_W-1:0] idx;
  logic              mem_op;
  logic              misaligned;
  logic              aligned_op;
  logic [4:0]        dest;
  logic [31:0]       rdata;
  logic              stall;

  assign idx        = bus.ALU_Result_in[ADDR_W+1:2];
  assign mem_op     = bus.MemRead_in | bus.MemWrite_in;
  assign misaligned = mem_op & (bus.ALU_Result_in[1:0] != 2'b00);
  assign aligned_op = mem_op & ~misaligned;
  assign dest       = bus.RegDest_in ? bus.rs_rt_rd_in[4:0] : bus.rs_rt_rd_in[9:5];
  // Reading before the store edge gives read-before-write for load+store ops.
  assign rdata      = mem_q[idx];

  // Upper address bits wrap away, and rs is not used in this stage.
  logic unused_bits;
  assign unused_bits = ^{bus.ALU_Result_in[31:ADDR_W+2], bus.rs_rt_rd_in[14:10]};

`ifdef DMEM_LATENCY_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_ACCESS = 2'd2} state_e;

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wait-state register: state and counter, both cleared by reset, which aborts a pending access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and stall: an aligned op stalls in IDLE and WAIT. It completes in ACCESS.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (aligned_op && (WAIT_CYCLES > 0)) begin
          stall   = 1'b1;
          cnt_d   = CNT_ONE;
          state_d = (CNT_ONE == CNT_MAX) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall   = 1'b1;
        cnt_d   = cnt_q + CNT_ONE;
        state_d = (cnt_d == CNT_MAX) ? ST_ACCESS : ST_WAIT;
      end
      ST_ACCESS: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.dbg_state = state_q;
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;
  assign stall         = 1'b0;
  assign bus.dbg_state = 2'd0;
`endif

  // Memory and MEM/WB register: a stall inserts a bubble, and a misaligned access raises only the flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      misalign_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (stall) begin
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      misalign_q <= 1'b0;
    end else if (misaligned) begin
      regwrite_q <= 1'b0;
      wreg_q     <= dest;
      wdata_q    <= '0;
      misalign_q <= 1'b1;
    end else begin
      regwrite_q <= bus.RegWrite_in;
      wreg_q     <= dest;
      wdata_q    <= bus.MemToReg_in ? rdata : bus.ALU_Result_in;
      misalign_q <= 1'b0;
      if (bus.MemWrite_in) mem_q[idx] <= bus.ReadData2_in;
    end
  end

  assign bus.RegWrite_out  = regwrite_q;
  assign bus.WriteReg_out  = wreg_q;
  assign bus.WriteData_out = wdata_q;
  assign bus.misalign_out  = misalign_q;
  assign bus.stall_out     = stall;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage. It runs directed steps and then random operations.
// Every operation is compared against a word-array model of the data memory.
module tb_mem_wb_stage;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam int WAITS  = 2;
`ifdef DMEM_LATENCY_EN
  localparam int EXP_WAIT = WAITS;
`else
  localparam int EXP_WAIT = 0;
`endif

  // Clock and reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_wb_stage_if bus();

  mem_wb_stage #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_CYCLES(WAITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic rw, input logic [31:0] alu, input logic [31:0] rd2,
                       input logic mr, input logic mw, input logic m2r, input logic rdst,
                       input logic [14:0] f);
    bus.RegWrite_in   = rw;
    bus.ALU_Result_in = alu;
    bus.ReadData2_in  = rd2;
    bus.MemRead_in    = mr;
    bus.MemWrite_in   = mw;
    bus.MemToReg_in   = m2r;
    bus.RegDest_in    = rdst;
    bus.rs_rt_rd_in   = f;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_regwrite"}, 32'(bus.RegWrite_out), 32'd0);
    chk({tag, "_writereg"}, 32'(bus.WriteReg_out), 32'd0);
    chk({tag, "_writedata"}, bus.WriteData_out, 32'd0);
    chk({tag, "_misalign"}, 32'(bus.misalign_out), 32'd0);
  endtask

  // Apply one operation. The model predicts the result, and the bench then waits out any stall.
  task automatic run_op(input string tag, input logic rw, input logic [31:0] alu,
                        input logic [31:0] rd2, input logic mr, input logic mw,
                        input logic m2r, input logic rdst, input logic [14:0] f);
    int          widx;
    int          n_stall;
    logic        is_mem;
    logic        is_mis;
    logic [31:0] e_wd;
    logic        e_rw;
    logic [4:0]  e_wr;
    int          e_stall;
    @(negedge clk);
    drive(rw, alu, rd2, mr, mw, m2r, rdst, f);
    widx    = int'((alu / 4) % DEPTH);
    is_mem  = mr | mw;
    is_mis  = is_mem && (alu % 4 != 0);
    e_wr    = rdst ? f[4:0] : f[9:5];
    e_stall = (is_mem && !is_mis) ? EXP_WAIT : 0;
    if (is_mis) begin
      e_rw = 1'b0;
      e_wd = 32'd0;
    end else begin
      e_rw = rw;
      e_wd = m2r ? ref_mem[widx] : alu;
      if (mw) ref_mem[widx] = rd2;
    end
    exp_q.push_back(e_wd);
    #1;
    n_stall = 0;
    while (bus.stall_out === 1'b1 && n_stall < 20) begin
      @(posedge clk);
      #1;
      n_stall++;
      chk({tag, "_bubble"}, {bus.WriteData_out[31:7], bus.WriteReg_out, bus.RegWrite_out,
          bus.misalign_out}, 32'd0);
    end
    chk({tag, "_stall_cycles"}, 32'(n_stall), 32'(e_stall));
    @(posedge clk);
    #1;
    chk({tag, "_writedata"}, bus.WriteData_out, exp_q.pop_front());
    chk({tag, "_writereg"}, 32'(bus.WriteReg_out), 32'(e_wr));
    chk({tag, "_regwrite"}, 32'(bus.RegWrite_out), 32'(e_rw));
    chk({tag, "_misalign"}, 32'(bus.misalign_out), 32'(is_mis));
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
  endtask

  initial begin
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        rdst;
    logic [14:0] f;

    // Reset state
    clear_model();
    reset = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 15'd0);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    chk("reset_stall", 32'(bus.stall_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Store and load back
    run_op("store_20", 1'b0, 32'h20, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 15'd0);
    run_op("load_20", 1'b1, 32'h20, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, {5'd1, 5'd7, 5'd2});

    // ALU passthrough
    run_op("alu_pass", 1'b1, 32'h12345678, 32'hFFFF0000, 1'b0, 1'b0, 1'b0, 1'b1,
           {5'd4, 5'd9, 5'd3});
    run_op("load_20_again", 1'b1, 32'h20, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, {5'd0, 5'd5, 5'd0});

    // Misaligned store has no effect, and the flag lasts one cycle
    run_op("mis_store_22", 1'b1, 32'h22, 32'h0BADF00D, 1'b0, 1'b1, 1'b0, 1'b1, {5'd0, 5'd0, 5'd6});
    run_op("load_20_after_mis", 1'b1, 32'h20, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, {5'd0, 5'd8, 5'd0});

    // Address wrap: 4*DEPTH+4 lands in word 1
    run_op("store_wrap", 1'b0, 32'(4 * DEPTH + 4), 32'hCAFE0001, 1'b0, 1'b1, 1'b0, 1'b0, 15'd0);
    run_op("load_word1", 1'b1, 32'h4, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, {5'd0, 5'd0, 5'd11});

    // Load and store together: the old data comes back, and the new data is written
    run_op("ld_st_20", 1'b1, 32'h20, 32'h55AA55AA, 1'b1, 1'b1, 1'b1, 1'b0, {5'd0, 5'd12, 5'd0});
    run_op("load_20_new", 1'b1, 32'h20, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, {5'd0, 5'd13, 5'd0});

    // Mid-run reset clears outputs at once and wipes memory
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    clear_model();
    #1;
    reset = 1'b1;
    run_op("load_10_after_reset", 1'b1, 32'h10, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, {5'd0, 5'd2, 5'd0});
    run_op("load_20_after_reset", 1'b1, 32'h20, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, {5'd0, 5'd2, 5'd0});

`ifdef DMEM_LATENCY_EN
    // Reset during a wait aborts the store and returns the FSM to idle
    @(negedge clk);
    drive(1'b0, 32'h30, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0, 1'b0, 15'd0);
    #1;
    chk("wait_abort_stall", 32'(bus.stall_out), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("wait_abort");
    chk("wait_abort_state", 32'(bus.dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op("load_30_after_abort", 1'b1, 32'h30, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, {5'd0, 5'd3, 5'd0});
`endif

    // Random operations against the model
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 3));
      addr = 32'($urandom_range(0, 15)) * 4;
      if ($urandom_range(0, 6) == 0) addr = addr + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) addr = addr + 32'(4 * DEPTH) * 32'($urandom_range(1, 50));
      data = $urandom;
      rw   = 1'($urandom_range(0, 1));
      rdst = 1'($urandom_range(0, 1));
      f    = 15'($urandom);
      case (kind)
        0:       run_op("rnd_store", rw, addr, data, 1'b0, 1'b1, 1'b0, rdst, f);
        1:       run_op("rnd_load", rw, addr, data, 1'b1, 1'b0, 1'b1, rdst, f);
        2:       run_op("rnd_alu", rw, $urandom, data, 1'b0, 1'b0, 1'b0, rdst, f);
        default: run_op("rnd_ldst", rw, addr, data, 1'b1, 1'b1, 1'b1, rdst, f);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
